// File: rtl/uart_frame_pkg.sv
// Shared constants and types for the ping-pong frame reader.
// Holds header defaults, the payload size, the index width and the FSM state set.
package uart_frame_pkg;

    localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
    localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

    localparam int FRAME_BYTES_DEFAULT = 384;

    // Byte index width: covers FRAME_BYTES + 255 + 3 bytes.
    localparam int IDX_W = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT,
        ST_SEND,
        ST_DRAIN
    } rd_state_t;

    typedef enum logic [2:0] {
        SRC_SYNC0,
        SRC_SYNC1,
        SRC_MAIN,
        SRC_VEC,
        SRC_CSUM
    } byte_src_t;

    // Where the byte at the current index comes from.
    typedef struct packed {
        byte_src_t        src;
        logic [IDX_W-1:0] offset;
        logic             last;
    } byte_sel_t;

    function automatic logic is_payload(input byte_src_t s);
        return (s == SRC_MAIN) || (s == SRC_VEC);
    endfunction

endpackage

// File: rtl/frame_byte_mux.sv
// Frame layout decoder for the ping-pong frame reader.
// Ports: idx (byte index), extra_len (vector tail length), sel (source, offset, last flag).
module frame_byte_mux
    import uart_frame_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT
) (
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       extra_len,
    output byte_sel_t        sel
);

    // One spare bit so the region bounds never wrap.
    localparam int IW = IDX_W + 1;
    localparam logic [IW-1:0] MAIN_END = IW'(FRAME_BYTES + 2);

    logic [IW-1:0] idx_w;
    logic [IW-1:0] vec_end;

    assign idx_w   = {1'b0, idx};
    assign vec_end = MAIN_END + IW'(extra_len);

    always_comb begin
        sel.src    = SRC_CSUM;
        sel.offset = '0;
        sel.last   = (idx_w == vec_end);
        unique case (1'b1)
            (idx_w == '0): begin
                sel.src = SRC_SYNC0;
            end
            (idx_w == IW'(1)): begin
                sel.src = SRC_SYNC1;
            end
            (idx_w >= IW'(2)) && (idx_w < MAIN_END): begin
                sel.src    = SRC_MAIN;
                sel.offset = IDX_W'(idx_w - IW'(2));
            end
            (idx_w >= MAIN_END) && (idx_w < vec_end): begin
                sel.src    = SRC_VEC;
                sel.offset = IDX_W'(idx_w - MAIN_END);
            end
            default: begin
                sel.src = SRC_CSUM;
            end
        endcase
    end

endmodule

// File: rtl/pingpong_frame_reader.sv
// Read side of the UART ping-pong capture path.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   bank_ready, bank_sel  bank complete pulse and bank number
//   extra_len             vector tail length, latched on accept
//   ram_bank, ram_addr    main-bank select and read address
//   ram_rdata             main-bank read data ([7:0] used)
//   vec_addr, vec_rdata   vector-RAM address and data ([7:0] used)
//   tx_start, tx_data     byte request towards uart_tx
//   tx_busy               uart_tx busy
//   busy                  frame in progress
//   frame_done, overrun   status pulses
module pingpong_frame_reader
    import uart_frame_pkg::*;
#(
    parameter int         ADDR_W      = 14,
    parameter int         FRAME_BYTES = FRAME_BYTES_DEFAULT,
    parameter logic [7:0] SYNC0       = SYNC0_DEFAULT,
    parameter logic [7:0] SYNC1       = SYNC1_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bank_ready,
    input  logic              bank_sel,
    input  logic [7:0]        extra_len,
    output logic              ram_bank,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [15:0]       ram_rdata,
    output logic [7:0]        vec_addr,
    input  logic [15:0]       vec_rdata,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    output logic              busy,
    output logic              frame_done,
    output logic              overrun
);

    rd_state_t        state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       len_q;
    logic [7:0]       csum;
    byte_sel_t        sel;
    logic [7:0]       rd_byte;
    logic             unused_hi;

    // The RAMs are 16 bits wide; only the low byte carries data.
    assign unused_hi = ^{ram_rdata[15:8], vec_rdata[15:8]};

    frame_byte_mux #(
        .FRAME_BYTES(FRAME_BYTES)
    ) u_mux (
        .idx      (idx),
        .extra_len(len_q),
        .sel      (sel)
    );

    always_comb begin
        rd_byte = 8'h00;
        unique case (1'b1)
            (sel.src == SRC_SYNC0): rd_byte = SYNC0;
            (sel.src == SRC_SYNC1): rd_byte = SYNC1;
            (sel.src == SRC_MAIN):  rd_byte = ram_rdata[7:0];
            (sel.src == SRC_VEC):   rd_byte = vec_rdata[7:0];
            default:                rd_byte = csum;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            len_q      <= '0;
            csum       <= '0;
            ram_bank   <= 1'b0;
            ram_addr   <= '0;
            vec_addr   <= '0;
            tx_start   <= 1'b0;
            tx_data    <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A bank arriving mid-frame is dropped and flagged.
            overrun    <= bank_ready && busy;

            unique case (state)
                ST_IDLE: begin
                    if (bank_ready) begin
                        ram_bank <= bank_sel;
                        len_q    <= extra_len;
                        idx      <= '0;
                        csum     <= '0;
                        busy     <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    // Only the addressed RAM moves; the other keeps its value.
                    if (sel.src == SRC_MAIN) begin
                        ram_addr <= ADDR_W'(sel.offset);
                    end
                    if (sel.src == SRC_VEC) begin
                        vec_addr <= sel.offset[7:0];
                    end
                    state <= ST_LOAD;
                end

                ST_LOAD: begin
                    tx_data <= rd_byte;
                    if (is_payload(sel.src)) begin
                        csum <= csum + rd_byte;
                    end
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    // Also covers a byte still in flight after reset.
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (tx_busy) begin
                        tx_start <= 1'b0;
                        if (sel.last) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= ST_FETCH;
                        end
                    end
                end

                ST_DRAIN: begin
                    if (!tx_busy) begin
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_frame_reader.sv
// Directed bench for pingpong_frame_reader.
// Expected frames are queued on bank_ready and compared as the uart model takes bytes.
module tb_pingpong_frame_reader;

    localparam int ADDR_W    = 14;
    localparam int FB        = 384;
    localparam int START_DLY = 3;
    localparam int BUSY_CYC  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              bank_ready;
    logic              bank_sel;
    logic [7:0]        extra_len;
    logic              ram_bank;
    logic [ADDR_W-1:0] ram_addr;
    logic [15:0]       ram_rdata;
    logic [7:0]        vec_addr;
    logic [15:0]       vec_rdata;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              busy;
    logic              frame_done;
    logic              overrun;

    logic [7:0] bank_mem [2][512];
    logic [7:0] vec_mem  [256];
    logic [7:0] exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dly = 0;
    int bcnt = 0;
    int rx_cnt = 0;
    int done_cnt = 0;
    int ovr_cnt = 0;
    int fall_cyc = 0;
    int first_start_cyc = 0;
    int first_fall = 0;
    int rst_cyc = 0;
    int vec_max = 0;
    int addr_max = 0;
    int r0, d0, o0, n;
    bit want_first = 0;
    bit in_rst = 0;
    logic prev_start = 1'b0;
    logic [7:0] cur_byte = 8'h00;

    always #5 clk = ~clk;

    assign ram_rdata = {8'hC3, bank_mem[ram_bank][ram_addr[8:0]]};
    assign vec_rdata = {8'h3C, vec_mem[vec_addr]};

    pingpong_frame_reader dut (
        .clk       (clk),
        .rst       (rst),
        .bank_ready(bank_ready),
        .bank_sel  (bank_sel),
        .extra_len (extra_len),
        .ram_bank  (ram_bank),
        .ram_addr  (ram_addr),
        .ram_rdata (ram_rdata),
        .vec_addr  (vec_addr),
        .vec_rdata (vec_rdata),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic b, input logic [7:0] len);
        logic [7:0] sum;
        sum = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < FB; i++) begin
            exp_q.push_back(bank_mem[b][i]);
            sum += bank_mem[b][i];
        end
        for (int i = 0; i < int'(len); i++) begin
            exp_q.push_back(vec_mem[i]);
            sum += vec_mem[i];
        end
        exp_q.push_back(sum);
    endtask

    // One clock: observe at the falling edge, then advance the uart model.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tx_start === 1'b1 && prev_start === 1'b0)
            chk("start_while_busy", tx_busy, 1'b0);
        if (tx_start === 1'b0 && prev_start === 1'b1 && !in_rst)
            chk("start_dropped_early", tx_busy, 1'b1);
        if (tx_start === 1'b1 && prev_start === 1'b1)
            chk("data_hold", tx_data, cur_byte);
        if (frame_done === 1'b1) done_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (busy === 1'b1) begin
            if (int'(vec_addr) > vec_max) vec_max = int'(vec_addr);
            if (int'(ram_addr) > addr_max) addr_max = int'(ram_addr);
        end
        prev_start = tx_start;

        if (dly != 0) begin
            dly--;
            if (dly == 0) begin
                tx_busy = 1'b1;
                bcnt = BUSY_CYC;
            end
        end else if (tx_busy) begin
            bcnt--;
            if (bcnt == 0) begin
                tx_busy = 1'b0;
                fall_cyc = cyc;
            end
        end else if (tx_start === 1'b1) begin
            dly = START_DLY;
            cur_byte = tx_data;
            rx_cnt++;
            if (want_first) begin
                want_first = 0;
                first_start_cyc = cyc;
                first_fall = fall_cyc;
            end
            chk("byte_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0)
                chk("byte_value", tx_data, exp_q.pop_front());
        end
    endtask

    task automatic pulse_ready(input logic b, input logic [7:0] len,
                               input bit push);
        bank_ready = 1'b1;
        bank_sel = b;
        extra_len = len;
        if (push) push_frame(b, len);
        tick();
        bank_ready = 1'b0;
        bank_sel = ~b;
        extra_len = 8'hEE;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk("frame_done_seen", frame_done, 1'b1);
    endtask

    task automatic wait_bytes(input int target, input int budget);
        int k;
        k = 0;
        while (rx_cnt < target && k < budget) begin
            tick();
            k++;
        end
        chk("byte_count_reached", rx_cnt >= target, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            bank_mem[0][i] = 8'(i);
            bank_mem[1][i] = 8'h00;
        end
        for (int i = 0; i < 256; i++) vec_mem[i] = 8'(i + 1);
        rst = 1'b1;
        bank_ready = 1'b0;
        bank_sel = 1'b0;
        extra_len = 8'h00;
        tx_busy = 1'b0;

        repeat (3) tick();
        chk("rst_tx_start", tx_start, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_vec_addr", vec_addr, 8'h00);
        chk("rst_ram_bank", ram_bank, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        tick();

        // Bank 0 counting pattern, no vector tail.
        r0 = rx_cnt; d0 = done_cnt; vec_max = 0; addr_max = 0;
        pulse_ready(1'b0, 8'd0, 1);
        chk("f1_busy_t1", busy, 1'b1);
        chk("f1_ram_bank", ram_bank, 1'b0);
        tick();
        tick();
        chk("f1_start_t3", tx_start, 1'b0);
        tick();
        chk("f1_start_t4", tx_start, 1'b1);
        chk("f1_sync0_t4", tx_data, 8'hA5);
        wait_done(10000);
        chk("f1_len", rx_cnt - r0, 387);
        chk("f1_csum", cur_byte, 8'h40);
        chk("f1_done_cnt", done_cnt - d0, 1);
        chk("f1_queue_empty", exp_q.size(), 0);
        chk("f1_addr_max", addr_max, FB - 1);
        chk("f1_vec_idle", vec_max, 0);
        repeat (5) tick();

        // Bank 1 zeros with a three-byte vector tail.
        r0 = rx_cnt; d0 = done_cnt; vec_max = 0;
        pulse_ready(1'b1, 8'd3, 1);
        chk("f2_ram_bank", ram_bank, 1'b1);
        wait_done(10000);
        chk("f2_len", rx_cnt - r0, 390);
        chk("f2_csum", cur_byte, 8'h06);
        chk("f2_vec_max", vec_max, 2);
        chk("f2_done_cnt", done_cnt - d0, 1);
        chk("f2_queue_empty", exp_q.size(), 0);
        repeat (5) tick();

        // Second bank_ready during byte 100 is dropped.
        r0 = rx_cnt; o0 = ovr_cnt; d0 = done_cnt;
        pulse_ready(1'b0, 8'd0, 1);
        wait_bytes(r0 + 100, 5000);
        pulse_ready(1'b1, 8'd9, 0);
        chk("ovr_pulse", overrun, 1'b1);
        tick();
        chk("ovr_one_cycle", overrun, 1'b0);
        wait_done(10000);
        chk("ovr_count", ovr_cnt - o0, 1);
        chk("ovr_len", rx_cnt - r0, 387);
        chk("ovr_done_cnt", done_cnt - d0, 1);
        chk("ovr_queue_empty", exp_q.size(), 0);
        n = rx_cnt;
        repeat (40) tick();
        chk("ovr_no_second_busy", busy, 1'b0);
        chk("ovr_no_second_bytes", rx_cnt - n, 0);

        // Reset while byte 200 is in flight in the uart.
        r0 = rx_cnt;
        pulse_ready(1'b1, 8'd3, 1);
        wait_bytes(r0 + 200, 5000);
        n = 0;
        while (tx_busy !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        rst = 1'b1;
        in_rst = 1;
        tick();
        rst_cyc = cyc;
        chk("rst_mid_start", tx_start, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_bank", ram_bank, 1'b0);
        chk("rst_mid_ram_addr", ram_addr, 0);
        rst = 1'b0;
        exp_q.delete();
        r0 = rx_cnt; d0 = done_cnt;
        want_first = 1;
        pulse_ready(1'b0, 8'd5, 1);
        in_rst = 0;
        wait_done(10000);
        chk("rst_first_after_fall", first_start_cyc > first_fall, 1'b1);
        chk("rst_fall_after_rst", first_fall >= rst_cyc, 1'b1);
        chk("rst_new_len", rx_cnt - r0, 392);
        chk("rst_new_done", done_cnt - d0, 1);
        chk("rst_queue_empty", exp_q.size(), 0);

        // bank_ready in the frame_done cycle starts the next frame.
        repeat (5) tick();
        r0 = rx_cnt;
        pulse_ready(1'b0, 8'd0, 1);
        wait_done(10000);
        o0 = ovr_cnt; d0 = done_cnt;
        pulse_ready(1'b1, 8'd3, 1);
        chk("b2b_busy", busy, 1'b1);
        chk("b2b_no_overrun", overrun, 1'b0);
        chk("b2b_bank", ram_bank, 1'b1);
        wait_done(10000);
        chk("b2b_ovr_count", ovr_cnt - o0, 0);
        chk("b2b_done_cnt", done_cnt - d0, 1);
        chk("b2b_len", rx_cnt - r0, 387 + 390);
        chk("b2b_queue_empty", exp_q.size(), 0);

        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
